// File: rtl/parallax_pkg.sv
// Shared definitions for the stereo parallax blocks (forward depth path and
// the depth-to-disparity projector).
//   state_t        : handshake FSM states of the projector
//   PIXEL_WIDTH    : width of pixel coordinates and disparity
//   DEPTH_WIDTH    : width of depth values in inches
//   DISPARITY_MAX  : largest representable disparity (saturation value)
package parallax_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int PIXEL_WIDTH   = 12;
    localparam int DEPTH_WIDTH   = 8;
    localparam int DISPARITY_MAX = 4095;

endpackage

// File: rtl/depth_to_disparity_if.sv
// Request/result handshake bundle of depth_to_disparity.
//   request : valid_in, ready_out, depth_in, x_1_in
//   result  : valid_out, ready_in, disparity_out, x_2_out, error_out
//   master  : the requester/consumer side; slave : the projector itself
interface depth_to_disparity_if;
    import parallax_pkg::*;

    logic                   valid_in;
    logic                   ready_out;
    logic [DEPTH_WIDTH-1:0] depth_in;
    logic [PIXEL_WIDTH-1:0] x_1_in;
    logic                   valid_out;
    logic                   ready_in;
    logic [PIXEL_WIDTH-1:0] disparity_out;
    logic [PIXEL_WIDTH-1:0] x_2_out;
    logic                   error_out;

    modport master (
        output valid_in, depth_in, x_1_in, ready_in,
        input  ready_out, valid_out, disparity_out, x_2_out, error_out
    );

    modport slave (
        input  valid_in, depth_in, x_1_in, ready_in,
        output ready_out, valid_out, disparity_out, x_2_out, error_out
    );

endinterface

// File: rtl/depth_to_disparity_restoring_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
//   clk_in/rst_in : clock, synchronous active-high reset
//   i_start       : load operands (ignored while busy)
//   i_dividend    : DIVIDEND_WIDTH-bit dividend
//   i_divisor     : DIVISOR_WIDTH-bit divisor (caller guarantees non-zero)
//   o_busy        : division in progress
//   o_done        : high during the last division cycle
//   o_quotient    : look-ahead quotient, final value while o_done is high,
//                   so a consumer can capture it on the same edge that
//                   computes the last bit (DIVIDEND_WIDTH cycles after load)
module restoring_divider #(
    parameter int DIVIDEND_WIDTH = 24,
    parameter int DIVISOR_WIDTH  = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      i_start,
    input  logic [DIVIDEND_WIDTH-1:0] i_dividend,
    input  logic [DIVISOR_WIDTH-1:0]  i_divisor,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [DIVIDEND_WIDTH-1:0] o_quotient
);
    localparam int CW = $clog2(DIVIDEND_WIDTH);

    logic [DIVIDEND_WIDTH:0]   r_rem;
    logic [DIVIDEND_WIDTH-1:0] r_quo;
    logic [DIVISOR_WIDTH-1:0]  r_div;
    logic [CW-1:0]             r_cnt;
    logic                      r_busy;

    logic [DIVIDEND_WIDTH+1:0] w_shift;
    logic [DIVIDEND_WIDTH+1:0] w_div_ext;
    logic [DIVIDEND_WIDTH:0]   w_rem_next;
    logic [DIVIDEND_WIDTH-1:0] w_quo_next;
    logic                      w_last;

    // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
    // r_quo doubles as the dividend shift register; quotient bits enter at the LSB.
    always_comb begin
        w_shift   = {r_rem, r_quo[DIVIDEND_WIDTH-1]};
        w_div_ext = {{(DIVIDEND_WIDTH+2-DIVISOR_WIDTH){1'b0}}, r_div};
        if (w_shift >= w_div_ext) begin
            w_rem_next = (DIVIDEND_WIDTH+1)'(w_shift - w_div_ext);
            w_quo_next = {r_quo[DIVIDEND_WIDTH-2:0], 1'b1};
        end else begin
            w_rem_next = w_shift[DIVIDEND_WIDTH:0];
            w_quo_next = {r_quo[DIVIDEND_WIDTH-2:0], 1'b0};
        end
        w_last = r_busy && (r_cnt == CW'(DIVIDEND_WIDTH - 1));
    end

    // Operand load, per-cycle step and cycle counting.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_div  <= i_divisor;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_cnt  <= r_cnt + CW'(1);
            r_busy <= !w_last;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = w_last;
    assign o_quotient = w_quo_next;

endmodule

// File: rtl/depth_to_disparity.sv
// Predicts stereo disparity and camera-2 x position for a target depth:
// disparity = min(floor(F*B / depth), 4095), x_2 = x_1 - disparity.
//   clk_in : system clock
//   rst_in : synchronous active-high reset
//   bus    : request (valid_in/ready_out/depth_in/x_1_in) and result
//            (valid_out/ready_in/disparity_out/x_2_out/error_out) handshake
// Results appear DIVIDEND_WIDTH edges after the accept edge (same edge for
// depth 0); error_out flags depth 0 or an x_2 that falls left of the frame.
module depth_to_disparity
    import parallax_pkg::*;
#(
    parameter int FOCAL_LENGTH      = 1,
    parameter int BASELINE_DISTANCE = 1,
    parameter int DIVIDEND_WIDTH    = 24
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    depth_to_disparity_if.slave  bus
);
    localparam int                        FB        = FOCAL_LENGTH * BASELINE_DISTANCE;
    localparam logic [DIVIDEND_WIDTH-1:0] DIVIDEND  = DIVIDEND_WIDTH'(FB);
    localparam logic [DIVIDEND_WIDTH-1:0] SAT_LIMIT = DIVIDEND_WIDTH'(DISPARITY_MAX);

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_valid;
    logic [PIXEL_WIDTH-1:0]    r_disp;
    logic [PIXEL_WIDTH-1:0]    r_x2;
    logic                      r_err;
    logic [PIXEL_WIDTH-1:0]    r_x1;

    logic                      w_valid_next;
    logic [PIXEL_WIDTH-1:0]    w_disp_next;
    logic [PIXEL_WIDTH-1:0]    w_x2_next;
    logic                      w_err_next;
    logic [PIXEL_WIDTH-1:0]    w_x1_next;
    logic                      w_start;
    logic                      w_div_busy;
    logic                      w_div_done;
    logic [DIVIDEND_WIDTH-1:0] w_quo;
    logic [PIXEL_WIDTH-1:0]    w_sat;
    logic [PIXEL_WIDTH:0]      w_diff;

    restoring_divider #(
        .DIVIDEND_WIDTH (DIVIDEND_WIDTH),
        .DIVISOR_WIDTH  (DEPTH_WIDTH)
    ) u_div (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_start    (w_start),
        .i_dividend (DIVIDEND),
        .i_divisor  (bus.depth_in),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    // Saturate the full quotient, then form x_1 - disparity with a borrow bit.
    always_comb begin
        if (w_quo > SAT_LIMIT) begin
            w_sat = PIXEL_WIDTH'(DISPARITY_MAX);
        end else begin
            w_sat = w_quo[PIXEL_WIDTH-1:0];
        end
        w_diff = {1'b0, r_x1} - {1'b0, w_sat};
    end

    // Handshake FSM next-state and next output values.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_valid_next = r_valid;
        w_disp_next  = r_disp;
        w_x2_next    = r_x2;
        w_err_next   = r_err;
        w_x1_next    = r_x1;
        case (r_state)
            IDLE: begin
                if (bus.valid_in) begin
                    w_x1_next = bus.x_1_in;
                    if (bus.depth_in == {DEPTH_WIDTH{1'b0}}) begin
                        w_state_next = DONE;
                        w_valid_next = 1'b1;
                        w_disp_next  = PIXEL_WIDTH'(DISPARITY_MAX);
                        w_x2_next    = {PIXEL_WIDTH{1'b0}};
                        w_err_next   = 1'b1;
                    end else begin
                        w_state_next = DIVIDE;
                        w_start      = !w_div_busy;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            DIVIDE: begin
                if (w_div_done) begin
                    w_state_next = DONE;
                    w_valid_next = 1'b1;
                    w_disp_next  = w_sat;
                    // A borrow means the point projects left of column 0.
                    if (w_diff[PIXEL_WIDTH]) begin
                        w_x2_next  = {PIXEL_WIDTH{1'b0}};
                        w_err_next = 1'b1;
                    end else begin
                        w_x2_next  = w_diff[PIXEL_WIDTH-1:0];
                        w_err_next = 1'b0;
                    end
                end else begin
                    w_state_next = DIVIDE;
                end
            end
            DONE: begin
                if (bus.ready_in) begin
                    w_state_next = IDLE;
                    w_valid_next = 1'b0;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_disp  <= '0;
            r_x2    <= '0;
            r_err   <= 1'b0;
            r_x1    <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            r_disp  <= w_disp_next;
            r_x2    <= w_x2_next;
            r_err   <= w_err_next;
            r_x1    <= w_x1_next;
        end
    end

    assign bus.ready_out     = (r_state == IDLE);
    assign bus.valid_out     = r_valid;
    assign bus.disparity_out = r_disp;
    assign bus.x_2_out       = r_x2;
    assign bus.error_out     = r_err;

endmodule

// File: tb/tb_depth_to_disparity.sv
// Directed bench: DUT A has F=600, B=4 (F*B=2400), DUT B has F=5000, B=1.
// Both use DIVIDEND_WIDTH=24, so a divided result is visible right after the
// 24th edge following the accept edge; a depth-0 result right after the
// accept edge itself.
module tb_depth_to_disparity;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    depth_to_disparity_if ifa ();
    depth_to_disparity_if ifb ();

    depth_to_disparity #(.FOCAL_LENGTH(600), .BASELINE_DISTANCE(4), .DIVIDEND_WIDTH(24))
        u_dut_a (.clk_in(clk), .rst_in(rst), .bus(ifa));
    depth_to_disparity #(.FOCAL_LENGTH(5000), .BASELINE_DISTANCE(1), .DIVIDEND_WIDTH(24))
        u_dut_b (.clk_in(clk), .rst_in(rst), .bus(ifb));

    // Bench drivers; sel routes them to DUT A (0) or DUT B (1).
    logic        sel = 1'b0;
    logic        drv_valid = 1'b0;
    logic [7:0]  drv_depth = 8'd0;
    logic [11:0] drv_x1 = 12'd0;
    logic        drv_ready_in = 1'b1;

    assign ifa.valid_in = sel ? 1'b0 : drv_valid;
    assign ifa.depth_in = drv_depth;
    assign ifa.x_1_in   = drv_x1;
    assign ifa.ready_in = sel ? 1'b1 : drv_ready_in;
    assign ifb.valid_in = sel ? drv_valid : 1'b0;
    assign ifb.depth_in = drv_depth;
    assign ifb.x_1_in   = drv_x1;
    assign ifb.ready_in = sel ? drv_ready_in : 1'b1;

    wire        mon_ready = sel ? ifb.ready_out     : ifa.ready_out;
    wire        mon_valid = sel ? ifb.valid_out     : ifa.valid_out;
    wire [11:0] mon_disp  = sel ? ifb.disparity_out : ifa.disparity_out;
    wire [11:0] mon_x2    = sel ? ifb.x_2_out       : ifa.x_2_out;
    wire        mon_err   = sel ? ifb.error_out     : ifa.error_out;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present a request, wait (bounded) for accept, return edges to valid_out.
    task automatic send(input logic [7:0] depth, input logic [11:0] x1, output int lat);
        @(negedge clk);
        drv_valid = 1'b1;
        drv_depth = depth;
        drv_x1    = x1;
        for (int i = 0; i < 60 && !mon_ready; i++) @(negedge clk);
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drv_depth = 8'hA5;
        drv_x1    = 12'hFFF;
        lat = 0;
        while (!mon_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_req(input string tag, input logic s, input logic [7:0] depth,
                           input logic [11:0] x1, input int exp_lat,
                           input logic [11:0] exp_disp, input logic [11:0] exp_x2,
                           input logic exp_err);
        int lat;
        sel = s;
        send(depth, x1, lat);
        check({tag, "_lat"},   lat,       exp_lat);
        check({tag, "_valid"}, mon_valid, 1);
        check({tag, "_disp"},  mon_disp,  exp_disp);
        check({tag, "_x2"},    mon_x2,    exp_x2);
        check({tag, "_err"},   mon_err,   exp_err);
        check({tag, "_busy"},  mon_ready, 0);
        // ready_in is high, so the next edge completes the handshake.
        @(posedge clk);
        #1;
        check({tag, "_vdrop"}, mon_valid, 0);
        check({tag, "_rdy"},   mon_ready, 1);
        check({tag, "_keep"},  mon_disp,  exp_disp);
    endtask

    initial begin
        int lat;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", ifa.valid_out, 0);
        check("rst_disp",  ifa.disparity_out, 0);
        check("rst_x2",    ifa.x_2_out, 0);
        check("rst_err",   ifa.error_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", ifa.ready_out, 1);

        // 2400/10 = 240, 640-240 = 400.
        run_req("t1", 1'b0, 8'd10, 12'd640, 24, 12'd240, 12'd400, 1'b0);
        // 2400/7 = 342 truncated, 500-342 = 158.
        run_req("t2", 1'b0, 8'd7,  12'd500, 24, 12'd342, 12'd158, 1'b0);
        // Depth 0 -> immediate error result.
        run_req("t3", 1'b0, 8'd0,  12'd300, 0,  12'd4095, 12'd0,  1'b1);
        // 240 > 100 -> out of frame.
        run_req("t4", 1'b0, 8'd10, 12'd100, 24, 12'd240, 12'd0,   1'b1);
        // 5000/1 saturates to 4095; 4095-4095 = 0 is still in frame.
        run_req("t5", 1'b1, 8'd1,  12'd4095, 24, 12'd4095, 12'd0, 1'b0);

        // Back-pressure: hold ready_in low for 10 cycles with a new request pending.
        sel = 1'b0;
        drv_ready_in = 1'b0;
        send(8'd10, 12'd640, lat);
        check("hold_lat", lat, 24);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drv_valid = 1'b1;
            drv_depth = 8'd3;
            drv_x1    = 12'd50;
            @(posedge clk);
            #1;
            check("hold_valid", mon_valid, 1);
            check("hold_disp",  mon_disp,  240);
            check("hold_x2",    mon_x2,    400);
            check("hold_ready", mon_ready, 0);
        end
        @(negedge clk);
        drv_valid    = 1'b0;
        drv_ready_in = 1'b1;
        @(posedge clk);
        #1;
        check("hold_vdrop", mon_valid, 0);
        check("hold_keep",  mon_x2,    400);
        check("hold_err",   mon_err,   0);

        // Reset during divide cycle 12 discards the request.
        @(negedge clk);
        drv_valid = 1'b1;
        drv_depth = 8'd10;
        drv_x1    = 12'd640;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_valid", mon_valid, 0);
        check("mrst_disp",  mon_disp,  0);
        check("mrst_x2",    mon_x2,    0);
        check("mrst_err",   mon_err,   0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_ready", mon_ready, 1);
        check("mrst_idle",  mon_valid, 0);
        run_req("t6", 1'b0, 8'd7, 12'd500, 24, 12'd342, 12'd158, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
